axi4_lite_master_bridge: RTL

Parametrised successor to the single-width native-to-AXI4-Lite bridge: converts the core's native valid/ready memory request port into AXI4-Lite master transactions. Address and data widths are configurable, and the AW and W channels handshake independently. BRESP/RRESP are checked and reported as an error flag, and a watchdog aborts a transaction if the slave never responds. It sits between the phoeniX core's memory port and the AXI4-Lite interconnect.

---
 rtl/axi4_lite_master_bridge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master_bridge.sv
// Native valid/ready memory request to AXI4-Lite master bridge with independent AW/W
// handshakes, response error reporting and a per-transaction watchdog.
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    axi_clk,
  input  logic                    resetn,
  input  logic                    valid,
  input  logic                    instr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           wdog_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    ready_q, error_q;
  logic [DATA_WIDTH-1:0]   rdata_q, wdata_q;
  logic [STRB-1:0]         wstrb_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any, busy, tmo;

  assign aw_hs  = awvalid_q & axi_awready;
  assign w_hs   = wvalid_q & axi_wready;
  assign b_hs   = bready_q & axi_bvalid;
  assign ar_hs  = arvalid_q & axi_arready;
  assign r_hs   = rready_q & axi_rvalid;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy   = (state_q != IDLE) && (state_q != DONE);
  // A handshake on the expiry edge wins; the saturated counter retries on the next edge.
  assign tmo    = WDOG_EN && busy && (wdog_q == LIMIT) && !hs_any;

  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
    end else begin
      if (state_q == IDLE)      wdog_q <= '0;
      else if (wdog_q != LIMIT) wdog_q <= wdog_q + 1'b1;

      if (tmo) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        rdata_q   <= '0;
        error_q   <= 1'b1;
        ready_q   <= 1'b1;
        state_q   <= DONE;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid) begin
              addr_q <= addr & ADDR_MASK;
              prot_q <= {instr, 1'b0, 1'b0};
              if (|wstrb) begin
                wdata_q   <= wdata;
                wstrb_q   <= wstrb;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= WR_ADDR_DATA;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= RD_ADDR;
              end
            end
          end
          WR_ADDR_DATA: begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
              bready_q <= 1'b1;
              state_q  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (b_hs) begin
              bready_q <= 1'b0;
              error_q  <= (axi_bresp != 2'b00);
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
          RD_ADDR: begin
            if (ar_hs) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (r_hs) begin
              rready_q <= 1'b0;
              rdata_q  <= axi_rdata;
              error_q  <= (axi_rresp != 2'b00);
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE: begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign error       = error_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_awprot  = prot_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_arprot  = prot_q;
  assign axi_rready  = rready_q;

endmodule
